data_merge_arbiter: RTL
=======================

// Module: data_merge_arbiter
// PURPOSE
//  Merges two valid/ready streams (even/odd lanes) into one output stream.
//  Strict-alternation mode rebuilds the original order split by the even/odd demux.
//  Round-robin mode shares the output among two independent requesters, with a
//  burst cap per grant. One registered output stage; throughput of 1 beat/cycle.
// PARAMETERS
//  DATA_WIDTH  1024  payload width of all data ports
//  MAX_BURST   4     RR mode: max consecutive beats for one source while the other waits (>=1)
//  CNT_WIDTH   32    width of per-source beat counters
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst_n       in   1           asynchronous active-low reset
//  mode_alt    in   1           1 = strict alternation 0,1,0,1...; 0 = round-robin with burst cap
//  data_in0    in   DATA_WIDTH  source 0 (even) payload
//  valid_in0   in   1           source 0 valid
//  ready_in0   out  1           source 0 accepted when valid_in0 && ready_in0
//  data_in1    in   DATA_WIDTH  source 1 (odd) payload
//  valid_in1   in   1           source 1 valid
//  ready_in1   out  1           source 1 accepted when valid_in1 && ready_in1
//  data_out    out  DATA_WIDTH  merged payload (registered)
//  valid_out   out  1           merged valid (registered)
//  ready_out   in   1           downstream ready
//  src_out     out  1           source index of the beat in data_out
//  beat_cnt0   out  CNT_WIDTH   beats accepted from source 0, wraps at 2^CNT_WIDTH
//  beat_cnt1   out  CNT_WIDTH   beats accepted from source 1, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset: valid_out=0, data_out=0, src_out=0, beat_cnt0/1=0, turn=0, owner=0, burst=0.
//  - load = !valid_out || ready_out. At most one input accepted per cycle; ready_inX=load && (grant==X).
//    ready may depend on valid; valid never depends on ready.
//  - Accepted beat appears on data_out/valid_out next cycle (latency 1); src_out=granted index.
//    No accept while load: valid_out <= 0 if ready_out, else hold data/valid/src unchanged.
//  - Alt mode (mode_alt=1): grant=turn, regardless of the other input. turn toggles only on an
//    accept. If valid_in[turn]=0, nothing is accepted (other source stalls, even if valid).
//  - RR mode (mode_alt=0), state {owner, burst}:
//      other = !owner. If valid_in[owner] && (burst<MAX_BURST || !valid_in[other]) -> grant owner.
//      Else if valid_in[other] -> grant other. Else grant owner, no accept.
//      On accept from owner: burst<=sat(burst+1). On accept from other: owner<=other, burst<=1.
//      Burst cap only forces a switch when the other source is valid. Work-conserving.
//  - turn is updated only in alt mode and owner/burst only in RR mode. A mode_alt change takes
//    effect the same cycle. The held output beat is unaffected.
//  - beat_cntX increments on each accept from X; wraps from all-ones to 0.
//  - Backpressure: a held beat is never lost or duplicated. Inputs not granted see ready=0.
//  - Async reset mid-transfer: the output beat is dropped, all state is cleared immediately,
//    and ready_in0/1=0 while rst_n=0.
// TESTING
//  1 Alt mode, src0 presents A0,A2 and src1 presents A1,A3 all valid, ready_out=1 ->
//    out A0,A1,A2,A3, src_out 0,1,0,1, first valid_out 1 cycle after first accept.
//  2 Alt mode, only valid_in1=1 after reset -> ready_in1=0, no output until valid_in0 beat passes.
//  3 RR, MAX_BURST=4, both sources always valid -> src_out pattern 0,0,0,0,1,1,1,1,0...
//    RR, only src1 valid -> src1 streams every cycle, no cap.
//  4 ready_out held low 5 cycles with valid_out=1 -> data_out/src_out stable, ready_in0/1=0.
//    On release, stream resumes with no gap, loss or duplicate.
//  5 Counter wrap with CNT_WIDTH=4 -> 16 beats from src0 give beat_cnt0=0, beat_cnt1 unchanged.
//  6 rst_n pulsed low while valid_out=1 and ready_out=0 -> valid_out=0 asynchronously,
//    counters=0, and the first beat after reset comes from src0 (alt) / owner 0 (RR).

Source files
------------

// File: rtl/data_merge_arbiter.sv
// Two-input valid/ready merge with a single registered output stage.
// Alternation mode restores even/odd order; round-robin mode shares bandwidth with a burst cap.
module data_merge_arbiter #(
  parameter int DATA_WIDTH = 1024,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_alt,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic                  valid_in0,
  output logic                  ready_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic                  valid_in1,
  output logic                  ready_in1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  src_out,
  output logic [CNT_WIDTH-1:0]  beat_cnt0,
  output logic [CNT_WIDTH-1:0]  beat_cnt1
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  src_q, src_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic                  turn_q, turn_d;
  logic                  owner_q, owner_d;
  logic [BW-1:0]         burst_q, burst_d;

  logic load, grant, accept;
  logic vin_owner, vin_other, vin_grant;

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] b);
    if (b >= BURST_CAP) return BURST_CAP;
    return b + BW'(1);
  endfunction

  always_comb begin
    load      = !valid_q || ready_out;
    vin_owner = owner_q ? valid_in1 : valid_in0;
    vin_other = owner_q ? valid_in0 : valid_in1;
    // The cap only yields the output when the other requester actually has data.
    if (mode_alt)
      grant = turn_q;
    else if (vin_owner && ((burst_q < BURST_CAP) || !vin_other))
      grant = owner_q;
    else if (vin_other)
      grant = !owner_q;
    else
      grant = owner_q;
    vin_grant = grant ? valid_in1 : valid_in0;
    accept    = load && vin_grant;
  end

  // Ready is forced low while reset is held so no beat slips in during reset.
  assign ready_in0 = rst_n && load && !grant;
  assign ready_in1 = rst_n && load && grant;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    turn_d  = turn_q;
    owner_d = owner_q;
    burst_d = burst_q;
    if (accept) begin
      data_d  = grant ? data_in1 : data_in0;
      valid_d = 1'b1;
      src_d   = grant;
      if (grant) cnt1_d = cnt1_q + CNT_WIDTH'(1);
      else       cnt0_d = cnt0_q + CNT_WIDTH'(1);
      if (mode_alt) begin
        turn_d = !turn_q;
      end else if (grant == owner_q) begin
        burst_d = sat_inc(burst_q);
      end else begin
        owner_d = grant;
        burst_d = BW'(1);
      end
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      turn_q  <= 1'b0;
      owner_q <= 1'b0;
      burst_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      turn_q  <= turn_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src_out   = src_q;
  assign beat_cnt0 = cnt0_q;
  assign beat_cnt1 = cnt1_q;

endmodule
